// File: rtl/array_allocator_pkg.sv
// rtl/array_allocator_pkg.sv - shared FSM/op types and default sizes for the array allocator
package array_allocator_pkg;
   localparam int MEM_ELEM_WIDTH_DEF = 12;
   localparam int N_ARRAYS_DEF       = 2000;

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, SERVE = 2'd2} state_t;
   typedef enum logic {OP_ALLOC = 1'b0, OP_FREE = 1'b1} op_t;
endpackage

// File: rtl/array_allocator_if.sv
// rtl/array_allocator_if.sv - request/response and status bundle of the array allocator
interface array_allocator_if #(parameter int W = 12);
   logic [1:0]   reqValid;
   logic [1:0]   reqFree;
   logic [W-1:0] reqIndex0;
   logic [W-1:0] reqIndex1;
   logic [1:0]   ack;
   logic [W-1:0] respIndex;
   logic         respError;
   logic         sizeWe;
   logic [W-1:0] sizeAddr;
   logic [W-1:0] allocs;
   logic [W-1:0] inUse;

   modport master (
      output reqValid, reqFree, reqIndex0, reqIndex1,
      input  ack, respIndex, respError, sizeWe, sizeAddr, allocs, inUse
   );
   modport slave (
      input  reqValid, reqFree, reqIndex0, reqIndex1,
      output ack, respIndex, respError, sizeWe, sizeAddr, allocs, inUse
   );
endinterface

// File: rtl/array_allocator_free_stack_ram.sv
// rtl/array_allocator_free_stack_ram.sv - free-index stack storage, one write port, registered read
module free_stack_ram #(
   parameter int W     = 12,
   parameter int DEPTH = 2000,
   parameter int AW    = 11
) (
   input  logic          clock,
   input  logic [AW-1:0] i_rd_addr,
   output logic [W-1:0]  o_rd_data,
   input  logic          i_we,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [W-1:0]  i_wr_data
);
   logic [W-1:0] r_mem [DEPTH];

   always_ff @(posedge clock) begin
      if (i_we) r_mem[i_wr_addr] <= i_wr_data;
      o_rd_data <= r_mem[i_rd_addr];
   end
endmodule

// File: rtl/array_allocator.sv
// rtl/array_allocator.sv - two-requester array index allocator with LIFO reuse of freed indices
module array_allocator
   import array_allocator_pkg::*;
#(
   parameter int MemoryElementWidth = MEM_ELEM_WIDTH_DEF,
   parameter int NArrays            = N_ARRAYS_DEF
) (
   input logic              clock,
   input logic              reset,
   array_allocator_if.slave bus
);
   localparam int           W     = MemoryElementWidth;
   localparam int           AW    = (NArrays > 1) ? $clog2(NArrays) : 1;
   localparam logic [W-1:0] N_MAX = W'(NArrays);
   localparam logic [W-1:0] ONE   = W'(1);

   state_t             r_state, w_state_n;
   op_t                r_op, w_op_n;
   logic               r_prio, w_prio_n, r_winner, w_winner_n;
   logic [W-1:0]       r_index, w_index_n, r_top, w_top_n;
   logic [W-1:0]       r_allocs, w_allocs_n, r_in_use_cnt, w_in_use_cnt_n;
   logic [NArrays-1:0] r_in_use, w_in_use_n;
   logic [1:0]         r_ack, w_ack_n, w_elig;
   logic [W-1:0]       r_resp_index, w_resp_index_n, r_size_addr, w_size_addr_n, w_ret;
   logic               r_resp_error, w_resp_error_n, r_size_we, w_size_we_n;
   logic [AW-1:0]      w_rd_addr;
   logic [W-1:0]       w_rd_data;
   logic               w_we;

   // A requester still holding reqValid in its ack cycle must not be re-granted.
   assign w_elig    = bus.reqValid & ~r_ack;
   assign w_rd_addr = (r_top == '0) ? '0 : AW'(r_top - ONE);

   free_stack_ram #(.W(W), .DEPTH(NArrays), .AW(AW)) u_free_stack (
      .clock     (clock),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data),
      .i_we      (w_we),
      .i_wr_addr (AW'(r_top)),
      .i_wr_data (r_index)
   );

   always_comb begin
      w_state_n       = r_state;
      w_op_n          = r_op;
      w_prio_n        = r_prio;
      w_winner_n      = r_winner;
      w_index_n       = r_index;
      w_top_n         = r_top;
      w_allocs_n      = r_allocs;
      w_in_use_cnt_n  = r_in_use_cnt;
      w_in_use_n      = r_in_use;
      w_ack_n         = '0;
      w_resp_index_n  = '0;
      w_resp_error_n  = 1'b0;
      w_size_we_n     = 1'b0;
      w_size_addr_n   = '0;
      w_we            = 1'b0;
      w_ret           = '0;
      unique case (r_state)
         IDLE: begin
            if (|w_elig) begin
               w_winner_n = (w_elig == 2'b11) ? r_prio : w_elig[1];
               w_prio_n   = ~w_winner_n;
               w_state_n  = GRANT;
            end
         end
         GRANT: begin
            w_op_n    = op_t'(bus.reqFree[r_winner]);
            w_index_n = r_winner ? bus.reqIndex1 : bus.reqIndex0;
            w_state_n = SERVE;
         end
         SERVE: begin
            w_ack_n[r_winner] = 1'b1;
            w_state_n         = IDLE;
            if (r_op == OP_ALLOC) begin
               if (r_top != '0 || r_allocs < N_MAX) begin
                  // Recycled indices take priority over fresh ones.
                  if (r_top != '0) begin
                     w_ret   = w_rd_data;
                     w_top_n = r_top - ONE;
                  end else begin
                     w_ret      = r_allocs;
                     w_allocs_n = r_allocs + ONE;
                  end
                  w_in_use_n[w_ret[AW-1:0]] = 1'b1;
                  w_in_use_cnt_n = r_in_use_cnt + ONE;
                  w_size_we_n    = 1'b1;
                  w_size_addr_n  = w_ret;
                  w_resp_index_n = w_ret;
               end else begin
                  w_resp_error_n = 1'b1;
               end
            end else if (r_index >= r_allocs || !r_in_use[r_index[AW-1:0]]) begin
               w_resp_error_n = 1'b1;
            end else begin
               w_we                        = 1'b1;
               w_top_n                     = r_top + ONE;
               w_in_use_n[r_index[AW-1:0]] = 1'b0;
               w_in_use_cnt_n              = r_in_use_cnt - ONE;
               w_resp_index_n              = r_index;
            end
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_op         <= OP_ALLOC;
         r_prio       <= 1'b0;
         r_winner     <= 1'b0;
         r_index      <= '0;
         r_top        <= '0;
         r_allocs     <= '0;
         r_in_use_cnt <= '0;
         r_in_use     <= '0;
         r_ack        <= '0;
         r_resp_index <= '0;
         r_resp_error <= 1'b0;
         r_size_we    <= 1'b0;
         r_size_addr  <= '0;
      end else begin
         r_state      <= w_state_n;
         r_op         <= w_op_n;
         r_prio       <= w_prio_n;
         r_winner     <= w_winner_n;
         r_index      <= w_index_n;
         r_top        <= w_top_n;
         r_allocs     <= w_allocs_n;
         r_in_use_cnt <= w_in_use_cnt_n;
         r_in_use     <= w_in_use_n;
         r_ack        <= w_ack_n;
         r_resp_index <= w_resp_index_n;
         r_resp_error <= w_resp_error_n;
         r_size_we    <= w_size_we_n;
         r_size_addr  <= w_size_addr_n;
      end
   end

   assign bus.ack       = r_ack;
   assign bus.respIndex = r_resp_index;
   assign bus.respError = r_resp_error;
   assign bus.sizeWe    = r_size_we;
   assign bus.sizeAddr  = r_size_addr;
   assign bus.allocs    = r_allocs;
   assign bus.inUse     = r_in_use_cnt;
endmodule

// File: tb/tb_array_allocator.sv
// tb/tb_array_allocator.sv - directed self-checking bench for array_allocator
module tb_array_allocator;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   array_allocator_if #(.W(12)) if0 ();
   array_allocator_if #(.W(12)) if1 ();

   array_allocator #(.MemoryElementWidth(12), .NArrays(2000)) dut0 (.clock(clk), .reset(rst_n), .bus(if0));
   array_allocator #(.MemoryElementWidth(12), .NArrays(4))    dut1 (.clock(clk), .reset(rst_n), .bus(if1));

   int n_cmp = 0;
   int n_bad = 0;

   logic        sel;
   logic [1:0]  m_ack;
   logic [11:0] m_idx, m_addr, m_allocs, m_inuse;
   logic        m_err, m_we;
   assign m_ack    = sel ? if1.ack       : if0.ack;
   assign m_idx    = sel ? if1.respIndex : if0.respIndex;
   assign m_err    = sel ? if1.respError : if0.respError;
   assign m_we     = sel ? if1.sizeWe    : if0.sizeWe;
   assign m_addr   = sel ? if1.sizeAddr  : if0.sizeAddr;
   assign m_allocs = sel ? if1.allocs    : if0.allocs;
   assign m_inuse  = sel ? if1.inUse     : if0.inUse;

   logic [11:0] g_idx, g_addr;
   logic        g_err, g_we;
   int          g_lat;

   task automatic drive(input logic d, input logic r, input logic v, input logic fr, input logic [11:0] idx);
      if (!d) begin
         if0.reqValid[r] = v; if0.reqFree[r] = fr;
         if (r) if0.reqIndex1 = idx; else if0.reqIndex0 = idx;
      end else begin
         if1.reqValid[r] = v; if1.reqFree[r] = fr;
         if (r) if1.reqIndex1 = idx; else if1.reqIndex0 = idx;
      end
   endtask

   task automatic op(input logic d, input logic r, input logic fr, input logic [11:0] idx);
      sel = d;
      @(posedge clk); #1;
      drive(d, r, 1'b1, fr, idx);
      g_lat = 99; g_idx = 12'hfff; g_addr = 12'hfff; g_err = 1'b1; g_we = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk); #1;
         if (m_ack[r]) begin
            g_lat = n; g_idx = m_idx; g_err = m_err; g_we = m_we; g_addr = m_addr;
            break;
         end
      end
      drive(d, r, 1'b0, fr, idx);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (if0.ack !== 2'b00) begin n_bad++; $display("FAIL rst_ack: got %0b want 0", if0.ack); end
      n_cmp++; if (if0.respIndex !== 12'd0) begin n_bad++; $display("FAIL rst_respIndex: got %0d want 0", if0.respIndex); end
      n_cmp++; if (if0.respError !== 1'b0) begin n_bad++; $display("FAIL rst_respError: got %0b want 0", if0.respError); end
      n_cmp++; if (if0.sizeWe !== 1'b0) begin n_bad++; $display("FAIL rst_sizeWe: got %0b want 0", if0.sizeWe); end
      n_cmp++; if (if0.sizeAddr !== 12'd0) begin n_bad++; $display("FAIL rst_sizeAddr: got %0d want 0", if0.sizeAddr); end
      n_cmp++; if (if0.allocs !== 12'd0) begin n_bad++; $display("FAIL rst_allocs: got %0d want 0", if0.allocs); end
      n_cmp++; if (if0.inUse !== 12'd0) begin n_bad++; $display("FAIL rst_inUse: got %0d want 0", if0.inUse); end
      n_cmp++; if (if1.allocs !== 12'd0) begin n_bad++; $display("FAIL rst_allocs_n4: got %0d want 0", if1.allocs); end
      rst_n = 1'b1;
   endtask

   task automatic test_alloc_seq();
      for (int i = 0; i < 3; i++) begin
         op(1'b0, 1'b0, 1'b0, 12'd0);
         n_cmp++; if (g_lat !== 3) begin n_bad++; $display("FAIL alloc%0d_latency: got %0d want 3", i, g_lat); end
         n_cmp++; if (g_idx !== 12'(i)) begin n_bad++; $display("FAIL alloc%0d_index: got %0d want %0d", i, g_idx, i); end
         n_cmp++; if (g_err !== 1'b0) begin n_bad++; $display("FAIL alloc%0d_error: got %0b want 0", i, g_err); end
         n_cmp++; if (g_we !== 1'b1) begin n_bad++; $display("FAIL alloc%0d_sizeWe: got %0b want 1", i, g_we); end
         n_cmp++; if (g_addr !== 12'(i)) begin n_bad++; $display("FAIL alloc%0d_sizeAddr: got %0d want %0d", i, g_addr, i); end
      end
      n_cmp++; if (m_allocs !== 12'd3) begin n_bad++; $display("FAIL alloc_allocs: got %0d want 3", m_allocs); end
      n_cmp++; if (m_inuse !== 12'd3) begin n_bad++; $display("FAIL alloc_inUse: got %0d want 3", m_inuse); end
      @(posedge clk); #1;
      n_cmp++; if (if0.sizeWe !== 1'b0) begin n_bad++; $display("FAIL sizeWe_one_cycle: got %0b want 0", if0.sizeWe); end
   endtask

   task automatic test_lifo();
      op(1'b0, 1'b0, 1'b1, 12'd1);
      n_cmp++; if (g_err !== 1'b0 || g_idx !== 12'd1) begin n_bad++; $display("FAIL free1: got idx %0d err %0b want idx 1 err 0", g_idx, g_err); end
      n_cmp++; if (g_we !== 1'b0) begin n_bad++; $display("FAIL free1_sizeWe: got %0b want 0", g_we); end
      op(1'b0, 1'b1, 1'b1, 12'd0);
      n_cmp++; if (g_err !== 1'b0 || g_idx !== 12'd0) begin n_bad++; $display("FAIL free0: got idx %0d err %0b want idx 0 err 0", g_idx, g_err); end
      n_cmp++; if (m_inuse !== 12'd1) begin n_bad++; $display("FAIL free_inUse: got %0d want 1", m_inuse); end
      op(1'b0, 1'b0, 1'b0, 12'd0);
      n_cmp++; if (g_idx !== 12'd0 || g_err !== 1'b0) begin n_bad++; $display("FAIL lifo_first: got idx %0d err %0b want idx 0 err 0", g_idx, g_err); end
      n_cmp++; if (g_addr !== 12'd0 || g_we !== 1'b1) begin n_bad++; $display("FAIL lifo_first_size: got addr %0d we %0b want addr 0 we 1", g_addr, g_we); end
      op(1'b0, 1'b0, 1'b0, 12'd0);
      n_cmp++; if (g_idx !== 12'd1 || g_err !== 1'b0) begin n_bad++; $display("FAIL lifo_second: got idx %0d err %0b want idx 1 err 0", g_idx, g_err); end
      n_cmp++; if (m_allocs !== 12'd3) begin n_bad++; $display("FAIL lifo_allocs: got %0d want 3", m_allocs); end
      n_cmp++; if (m_inuse !== 12'd3) begin n_bad++; $display("FAIL lifo_inUse: got %0d want 3", m_inuse); end
   endtask

   task automatic test_free_errors();
      op(1'b0, 1'b0, 1'b1, 12'd5);
      n_cmp++; if (g_err !== 1'b1) begin n_bad++; $display("FAIL free_oob_error: got %0b want 1", g_err); end
      n_cmp++; if (m_inuse !== 12'd3) begin n_bad++; $display("FAIL free_oob_inUse: got %0d want 3", m_inuse); end
      op(1'b0, 1'b0, 1'b1, 12'd1);
      n_cmp++; if (g_err !== 1'b0) begin n_bad++; $display("FAIL free_first_error: got %0b want 0", g_err); end
      op(1'b0, 1'b0, 1'b1, 12'd1);
      n_cmp++; if (g_err !== 1'b1 || g_lat !== 3) begin n_bad++; $display("FAIL double_free: got err %0b lat %0d want err 1 lat 3", g_err, g_lat); end
      n_cmp++; if (m_inuse !== 12'd2) begin n_bad++; $display("FAIL double_free_inUse: got %0d want 2", m_inuse); end
   endtask

   task automatic test_drop_valid();
      int lat;
      sel = 1'b0; lat = 99;
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b1, 1'b0, 12'd0);
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk); #1;
         if (n == 1) drive(1'b0, 1'b1, 1'b0, 1'b0, 12'd0);
         if (if0.ack[1]) begin lat = n; break; end
      end
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL drop_valid_ack: got latency %0d want 3", lat); end
      n_cmp++; if (if0.respIndex !== 12'd1) begin n_bad++; $display("FAIL drop_valid_index: got %0d want 1", if0.respIndex); end
      n_cmp++; if (if0.inUse !== 12'd3) begin n_bad++; $display("FAIL drop_valid_inUse: got %0d want 3", if0.inUse); end
   endtask

   task automatic test_back_to_back();
      int k, c0, c1;
      logic [1:0] exp_ack;
      k = 0; c0 = 0; c1 = 0; sel = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1;
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 12'd0);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 12'd0);
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(posedge clk); #1;
         if (if0.ack != 2'b00) begin
            exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++; if (if0.ack !== exp_ack) begin n_bad++; $display("FAIL rr_order%0d: got %0b want %0b", k, if0.ack, exp_ack); end
            n_cmp++; if (if0.respIndex !== 12'(k)) begin n_bad++; $display("FAIL rr_index%0d: got %0d want %0d", k, if0.respIndex, k); end
            n_cmp++; if (cyc !== 3 * (k + 1)) begin n_bad++; $display("FAIL rr_timing%0d: got cycle %0d want %0d", k, cyc, 3 * (k + 1)); end
            if (if0.ack[0]) begin c0++; if (c0 == 4) drive(1'b0, 1'b0, 1'b0, 1'b0, 12'd0); end
            if (if0.ack[1]) begin c1++; if (c1 == 4) drive(1'b0, 1'b1, 1'b0, 1'b0, 12'd0); end
            k++;
            if (k == 8) break;
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 12'd0);
      n_cmp++; if (k !== 8) begin n_bad++; $display("FAIL rr_ack_count: got %0d want 8", k); end
      n_cmp++; if (if0.allocs !== 12'd8) begin n_bad++; $display("FAIL rr_allocs: got %0d want 8", if0.allocs); end
   endtask

   task automatic test_full();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         op(1'b1, 1'b0, 1'b0, 12'd0);
         n_cmp++; if (g_idx !== 12'(i) || g_err !== 1'b0) begin n_bad++; $display("FAIL full_alloc%0d: got idx %0d err %0b want idx %0d err 0", i, g_idx, g_err, i); end
      end
      op(1'b1, 1'b0, 1'b0, 12'd0);
      n_cmp++; if (g_err !== 1'b1) begin n_bad++; $display("FAIL full_error: got %0b want 1", g_err); end
      n_cmp++; if (g_idx !== 12'd0) begin n_bad++; $display("FAIL full_index: got %0d want 0", g_idx); end
      n_cmp++; if (g_we !== 1'b0) begin n_bad++; $display("FAIL full_sizeWe: got %0b want 0", g_we); end
      n_cmp++; if (m_allocs !== 12'd4 || m_inuse !== 12'd4) begin n_bad++; $display("FAIL full_counts: got allocs %0d inUse %0d want 4 4", m_allocs, m_inuse); end
      op(1'b1, 1'b1, 1'b1, 12'd2);
      n_cmp++; if (g_err !== 1'b0 || g_idx !== 12'd2) begin n_bad++; $display("FAIL full_free: got idx %0d err %0b want idx 2 err 0", g_idx, g_err); end
      op(1'b1, 1'b0, 1'b0, 12'd0);
      n_cmp++; if (g_err !== 1'b0 || g_idx !== 12'd2) begin n_bad++; $display("FAIL full_realloc: got idx %0d err %0b want idx 2 err 0", g_idx, g_err); end
      n_cmp++; if (m_allocs !== 12'd4 || m_inuse !== 12'd4) begin n_bad++; $display("FAIL full_realloc_counts: got allocs %0d inUse %0d want 4 4", m_allocs, m_inuse); end
   endtask

   task automatic test_reset_mid();
      op(1'b0, 1'b0, 1'b0, 12'd0);
      op(1'b0, 1'b0, 1'b0, 12'd0);
      n_cmp++; if (m_allocs !== 12'd2) begin n_bad++; $display("FAIL mid_setup_allocs: got %0d want 2", m_allocs); end
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 12'd0);
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk); #1;
         n_cmp++; if (if0.ack !== 2'b00) begin n_bad++; $display("FAIL mid_reset_ack%0d: got %0b want 0", n, if0.ack); end
      end
      n_cmp++; if (if0.respIndex !== 12'd0 || if0.respError !== 1'b0) begin n_bad++; $display("FAIL mid_reset_resp: got idx %0d err %0b want 0 0", if0.respIndex, if0.respError); end
      n_cmp++; if (if0.sizeWe !== 1'b0 || if0.sizeAddr !== 12'd0) begin n_bad++; $display("FAIL mid_reset_size: got we %0b addr %0d want 0 0", if0.sizeWe, if0.sizeAddr); end
      n_cmp++; if (if0.allocs !== 12'd0 || if0.inUse !== 12'd0) begin n_bad++; $display("FAIL mid_reset_counts: got allocs %0d inUse %0d want 0 0", if0.allocs, if0.inUse); end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
      rst_n = 1'b1;
      op(1'b0, 1'b0, 1'b0, 12'd0);
      n_cmp++; if (g_idx !== 12'd0 || g_err !== 1'b0 || g_lat !== 3) begin n_bad++; $display("FAIL mid_reset_next: got idx %0d err %0b lat %0d want 0 0 3", g_idx, g_err, g_lat); end
   endtask

   initial begin
      sel = 1'b0;
      rst_n = 1'b0;
      if0.reqValid = 2'b00; if0.reqFree = 2'b00; if0.reqIndex0 = '0; if0.reqIndex1 = '0;
      if1.reqValid = 2'b00; if1.reqFree = 2'b00; if1.reqIndex0 = '0; if1.reqIndex1 = '0;
      test_reset();
      test_alloc_seq();
      test_lifo();
      test_free_errors();
      test_drop_valid();
      test_back_to_back();
      test_full();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
